axis_byte_packer: RTL
=====================

# axis_byte_packer

Packs the 8-bit AXI-stream RX output of `ftdi_245fifo_top` into wider AXI-stream words with `tkeep` and `tlast`. It sits directly downstream of the FTDI RX path, in front of user logic or a TX-side stage. Word boundaries come from three events: all lanes filled, upstream `i_tlast`, or an idle-flush timeout. The timeout means a short USB transfer is never stranded in a partial word.

## Interface
- `OUT_EW`, default 2: output width exponent. Output has 2^OUT_EW byte lanes; legal values are 1..4.
- `FLUSH_CYCLES`, default 1024: idle cycles before a partial word is flushed. 0 disables flushing. Counter width is clog2(FLUSH_CYCLES+1).

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous and active-high.
- `i_tready` output 1: byte accepted when `i_tvalid & i_tready`.
- `i_tvalid` input 1: input byte valid.
- `i_tdata` input 8: input byte.
- `i_tlast` input 1: marks the last byte of a packet.
- `o_tready` input 1: downstream ready.
- `o_tvalid` output 1: output word valid.
- `o_tdata` output 8<<OUT_EW: packed word, little-endian lanes.
- `o_tkeep` output 1<<OUT_EW: lane-valid mask.
- `o_tlast` output 1: packet end.

## Operation
**Datapath.** An accumulation register (`acc`, lane count `cnt`) feeds a single-entry output register (`o_*`).
- `i_tready = !o_tvalid | o_tready`, i.e. the output register is free or is being drained this cycle. This is combinational.
- Each accepted byte is written to lane `cnt`, at bits [8*cnt+7 : 8*cnt].

**Launch.** An accepted byte launches a word into the output register in the same cycle if either:
- it fills the last lane (`cnt == 2^OUT_EW-1`); `o_tlast` then equals `i_tlast`, or
- `i_tlast` = 1 on any lane; `o_tlast` = 1.

On launch:
- `o_tkeep` gets contiguous ones in lanes 0..cnt.
- Unfilled lanes of `o_tdata` are 0.
- `cnt` returns to 0 and `acc` clears.

**Flush timer.**
- Increments each cycle while `cnt > 0` and no byte is accepted.
- Clears on any accepted byte and whenever `cnt == 0`.
- At `FLUSH_CYCLES`, if the output register is free, the partial word launches with `o_tlast` = 0 and `tkeep` covering lanes 0..cnt-1.
- If the output register is not free, the timer saturates and the flush launches on the first free cycle.
- When `FLUSH_CYCLES` = 0 the timer is removed and no flush ever occurs.

**Output register.**
- Holds `o_tdata`, `o_tkeep` and `o_tlast` stable while `o_tvalid & !o_tready`.
- Clears `o_tvalid` on handshake unless a new word launches in the same cycle.

## Timing
**Reset.** While `rst` = 1, regardless of clock:
- `o_tvalid`=0, `o_tdata`=0, `o_tkeep`=0, `o_tlast`=0, `cnt`=0, `acc`=0, timer=0.
- `i_tready` = 1 immediately after reset.

**Latency and throughput.**
- Launch latency is 1 cycle: a byte accepted at edge N that completes a word gives `o_tvalid`=1 after edge N.
- Sustained throughput is 1 byte/cycle with `o_tready` held at 1; the output is valid every 2^OUT_EW cycles.

**Back-pressure.**
- With `o_tvalid`=1 and `o_tready`=0, `i_tready`=0 and `acc` and `cnt` are frozen. No byte is lost or duplicated.

**Simultaneous events.**
- A byte accepted on the flush-expiry cycle takes priority: the byte is stored (or launches, if it completes a word or carries `i_tlast`), the timer clears, and no separate flush occurs.
- Handshake and launch in the same cycle: the output register loads the new word and `o_tvalid` stays 1.

**Reset mid-operation.**
- The partial word and any pending output word are discarded and not emitted.

## Test plan
All scenarios use OUT_EW=2.
- **Continuous packing.** Bytes 01..08 back-to-back, `o_tready`=1, `i_tlast`=0 → two words, `0x04030201` then `0x08070605`, each `tkeep`=F, `tlast`=0. The first `o_tvalid` appears 1 cycle after byte 04 is accepted.
- **Short packet.** Bytes 01,02,03 with `i_tlast` on 03 → `0x00030201`, `tkeep`=0x7, `tlast`=1; `cnt` returns to 0.
- **Idle flush.** FLUSH_CYCLES=16. Bytes AA,BB, then `i_tvalid`=0 → after exactly 16 idle cycles, `0x0000BBAA`, `tkeep`=0x3, `tlast`=0.
- **Flush pre-empted.** FLUSH_CYCLES=16. Byte CC arrives on idle cycle 16 → no flush; the timer clears and the word continues to fill.
- **Back-pressure.** Full word pending with `o_tready`=0 for 10 cycles → `i_tready`=0 and `o_tdata` stable throughout. Release `o_tready` → word accepted once, and input resumes the same cycle.
- **Reset mid-word.** Assert `rst` after bytes 01,02 → all outputs 0. Then byte 11 with `i_tlast` → `0x00000011`, `tkeep`=0x1, `tlast`=1, with no trace of 01 or 02.

Source files
------------

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-stream into 2^OUT_EW-byte words with tkeep/tlast.
// A word launches when full, on i_tlast, or after FLUSH_CYCLES idle cycles.
module axis_byte_packer #(
  parameter int OUT_EW       = 2,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      i_tready,
  input  logic                      i_tvalid,
  input  logic [7:0]                i_tdata,
  input  logic                      i_tlast,
  input  logic                      o_tready,
  output logic                      o_tvalid,
  output logic [(8<<OUT_EW)-1:0]    o_tdata,
  output logic [(1<<OUT_EW)-1:0]    o_tkeep,
  output logic                      o_tlast
);

  localparam int LANES = 1 << OUT_EW;
  localparam int DW    = 8 * LANES;
  localparam int CW    = OUT_EW;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic [DW-1:0]    acc_q, acc_d, merged;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic [DW-1:0]    o_tdata_q, o_tdata_d;
  logic [LANES-1:0] o_tkeep_q, o_tkeep_d;
  logic             o_tlast_q, o_tlast_d;
  logic [LANES-1:0] keep_byte, keep_flush;
  logic             out_free, accept, launch_byte, flush_fire;

  assign out_free    = !o_tvalid_q || o_tready;
  assign accept      = i_tvalid && out_free;
  assign launch_byte = accept && (i_tlast || (cnt_q == LAST_LANE));

  // Per-lane view of the accumulator with the incoming byte dropped into lane cnt.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(gi);
    assign merged[8*gi +: 8] = (accept && (cnt_q == LANE)) ? i_tdata : acc_q[8*gi +: 8];
    assign keep_byte[gi]     = (LANE <= cnt_q);
    assign keep_flush[gi]    = (LANE < cnt_q);
  end

  if (FLUSH_CYCLES > 0) begin : g_flush
    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] EXPIRE = TW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] SAT    = TW'(FLUSH_CYCLES);
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
      timer_d = timer_q;
      if (accept || (cnt_q == '0)) timer_d = '0;
      else if (timer_q != SAT)     timer_d = timer_q + 1'b1;
    end

    // Fires on the FLUSH_CYCLES-th idle cycle; a byte arriving that cycle wins.
    assign flush_fire = !accept && out_free && (cnt_q != '0) && (timer_q >= EXPIRE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
    end
  end else begin : g_no_flush
    assign flush_fire = 1'b0;
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tkeep_d  = o_tkeep_q;
    o_tlast_d  = o_tlast_q;
    if (launch_byte) begin
      o_tvalid_d = 1'b1;
      o_tdata_d  = merged;
      o_tkeep_d  = keep_byte;
      o_tlast_d  = i_tlast;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (flush_fire) begin
      o_tvalid_d = 1'b1;
      o_tdata_d  = acc_q;
      o_tkeep_d  = keep_flush;
      o_tlast_d  = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        cnt_d = cnt_q + 1'b1;
      end
      if (o_tready) o_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tkeep_q  <= '0;
      o_tlast_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tkeep_q  <= o_tkeep_d;
      o_tlast_q  <= o_tlast_d;
    end
  end

  assign i_tready = out_free;
  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tkeep  = o_tkeep_q;
  assign o_tlast  = o_tlast_q;

endmodule
